// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding, ratio limits and counter sizing for the PLL reconfiguration sequencer
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    RST_HOLD    = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RETRY_CHK   = 3'd3,
    IDLE_LOCKED = 3'd4,
    FAULT       = 3'd5
  } state_t;
  localparam int PLL_DEFAULT_ODIV0 = 5;
  localparam int PLL_DIV_MIN = 1;
  localparam int PLL_DIV_MAX = 128;
  // bits needed for a counter that must hold the value n itself
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level, reset value 0
//   clk, rst : destination clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences PLL ratio changes, reset, qualified lock, retries and lock-loss recovery
//   req_valid/req_odiv/req_ready : ratio change handshake, ready only when idle or faulted
//   pll_lock                     : raw asynchronous PLL lock
//   pll_rst/dyn_odiv0            : PLL reset and CLKOUT0 ratio
//   clk_ok                       : ADC clock qualified
//   busy/done/err_range/fault    : sequence status, done and err_range are 1-cycle pulses
//   retry_cnt                    : attempts used in the last sequence
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int DIV_MIN       = pll_ctrl_pkg::PLL_DIV_MIN,
  parameter int DIV_MAX       = pll_ctrl_pkg::PLL_DIV_MAX,
  parameter int DEFAULT_ODIV0 = pll_ctrl_pkg::PLL_DEFAULT_ODIV0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [9:0] req_odiv,
  output logic       req_ready,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [9:0] dyn_odiv0,
  output logic       clk_ok,
  output logic       busy,
  output logic       done,
  output logic       err_range,
  output logic       fault,
  output logic [1:0] retry_cnt
);
  localparam int RW = cw(RST_CYCLES);
  localparam int TW = cw(LOCK_TIMEOUT);
  localparam int SW = cw(STABLE_CYCLES);
  state_t state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [9:0] odiv_q, odiv_d;
  logic [1:0] retry_q, retry_d;
  logic fault_q, fault_d, done_q, done_d, err_q, err_d;
  logic lock_s, accept, in_range;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_lock),
    .q  (lock_s)
  );
  assign req_ready = (state_q == IDLE_LOCKED) || (state_q == FAULT);
  assign busy      = !req_ready;
  assign pll_rst   = (state_q == RST_HOLD) || (state_q == FAULT);
  // drops combinationally with lock_s so capture is gated the same cycle
  assign clk_ok    = (state_q == IDLE_LOCKED) && lock_s;
  assign accept    = req_valid && req_ready;
  assign in_range  = (req_odiv >= 10'(DIV_MIN)) && (req_odiv <= 10'(DIV_MAX));
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    odiv_d  = odiv_q;
    retry_d = retry_q;
    fault_d = fault_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RST_HOLD: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q >= RW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          rcnt_d  = '0;
          tcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      WAIT_LOCK: begin
        tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
        // the cycle that first sees lock counts as the first stable cycle
        if (lock_s) begin
          state_d = STABLE;
          scnt_d  = SW'(1);
        end else if (tcnt_q >= TW'(LOCK_TIMEOUT - 1)) state_d = RETRY_CHK;
      end
      STABLE: begin
        // timeout keeps running across lock glitches so a flapping PLL still fails
        tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
        scnt_d = (&scnt_q) ? scnt_q : scnt_q + 1'b1;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          scnt_d  = '0;
        end else if (scnt_q >= SW'(STABLE_CYCLES - 1)) begin
          state_d = IDLE_LOCKED;
          done_d  = 1'b1;
        end
      end
      RETRY_CHK: begin
        if (retry_q < 2'(MAX_RETRY)) begin
          retry_d = (&retry_q) ? retry_q : retry_q + 2'd1;
          state_d = RST_HOLD;
          rcnt_d  = '0;
        end else begin
          state_d = FAULT;
          fault_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      IDLE_LOCKED: begin
        if (!lock_s) begin
          retry_d = '0;
          state_d = RST_HOLD;
          rcnt_d  = '0;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = RST_HOLD;
    endcase
    // an accepted in-range request overrides a simultaneous lock drop
    if (accept && in_range) begin
      odiv_d  = req_odiv;
      fault_d = 1'b0;
      retry_d = '0;
      state_d = RST_HOLD;
      rcnt_d  = '0;
    end
    if (accept && !in_range) err_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_HOLD;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      odiv_q  <= 10'(DEFAULT_ODIV0);
      retry_q <= '0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      odiv_q  <= odiv_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign dyn_odiv0 = odiv_q;
  assign retry_cnt = retry_q;
  assign fault     = fault_q;
  assign done      = done_q;
  assign err_range = err_q;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed checks of the PLL sequencer, default instance plus a short-timeout instance
module tb_pll_reconfig_ctrl;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_a, req_valid_a, req_ready_a, pll_lock_a, pll_rst_a, clk_ok_a, busy_a, done_a, err_a, fault_a;
  logic [9:0] req_odiv_a, dyn_a;
  logic [1:0] retry_a;
  logic rst_b, req_valid_b, req_ready_b, pll_lock_b, pll_rst_b, clk_ok_b, busy_b, done_b, err_b, fault_b;
  logic [9:0] req_odiv_b, dyn_b;
  logic [1:0] retry_b;
  int tests = 0, fails = 0;
  int dly_a = 200;
  bit kill_a = 1'b0;
  pll_reconfig_ctrl u_dut (
    .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_odiv(req_odiv_a), .req_ready(req_ready_a),
    .pll_lock(pll_lock_a), .pll_rst(pll_rst_a), .dyn_odiv0(dyn_a), .clk_ok(clk_ok_a), .busy(busy_a),
    .done(done_a), .err_range(err_a), .fault(fault_a), .retry_cnt(retry_a)
  );
  pll_reconfig_ctrl #(.LOCK_TIMEOUT(100)) u_to (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_odiv(req_odiv_b), .req_ready(req_ready_b),
    .pll_lock(pll_lock_b), .pll_rst(pll_rst_b), .dyn_odiv0(dyn_b), .clk_ok(clk_ok_b), .busy(busy_b),
    .done(done_b), .err_range(err_b), .fault(fault_b), .retry_cnt(retry_b)
  );
  // PLL model: lock comes up dly_a cycles after RST falls, kill_a forces it low
  initial begin
    int ca;
    ca = 0;
    pll_lock_a = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (pll_rst_a) begin
        ca = 0;
        pll_lock_a = 1'b0;
      end else begin
        if (ca < dly_a) ca++;
        pll_lock_a = (ca >= dly_a) && !kill_a;
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic run_until_ok(input int budget, output int lock_at, output int ok_at, output int dones);
    lock_at = -1;
    ok_at = -1;
    dones = 0;
    for (int i = 0; i < budget && ok_at < 0; i++) begin
      @(posedge clk); #3;
      if (lock_at < 0 && pll_lock_a) lock_at = i;
      if (done_a) dones++;
      if (clk_ok_a) ok_at = i;
    end
  endtask
  task automatic request_a(input logic [9:0] v);
    @(negedge clk);
    req_valid_a = 1'b1;
    req_odiv_a = v;
    @(posedge clk); #3;
    req_valid_a = 1'b0;
  endtask
  task automatic relock_checks(input string tag, input logic [9:0] want_div);
    int l, o, d;
    run_until_ok(3000, l, o, d);
    tests++; if (o < 0) begin fails++; $display("FAIL %s_timeout: clk_ok never rose", tag); end
    tests++; if (o - l !== 1026) begin fails++; $display("FAIL %s_lock_to_ok: got %0d want 1026", tag, o - l); end
    tests++; if (d !== 1 || done_a !== 1'b1) begin fails++; $display("FAIL %s_done: got %0d pulses done=%b want 1", tag, d, done_a); end
    tests++; if (dyn_a !== want_div) begin fails++; $display("FAIL %s_div: got %0d want %0d", tag, dyn_a, want_div); end
  endtask
  task automatic test_reset;
    int k;
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if ({pll_rst_a, clk_ok_a, busy_a, done_a, err_a, fault_a, req_ready_a} !== 7'b1010000 || dyn_a !== 10'd5 || retry_a !== 2'd0) begin
      fails++; $display("FAIL reset_values: rst=%b ok=%b busy=%b done=%b err=%b fault=%b rdy=%b div=%0d retry=%0d want 1 0 1 0 0 0 0 5 0",
        pll_rst_a, clk_ok_a, busy_a, done_a, err_a, fault_a, req_ready_a, dyn_a, retry_a);
    end
    rst_a = 1'b0;
    for (k = 1; k < 40; k++) begin
      @(posedge clk); #3;
      if (!pll_rst_a) break;
    end
    tests++; if (k !== 16) begin fails++; $display("FAIL reset_rst_hold: got %0d cycles want 16", k); end
    relock_checks("reset", 10'd5);
    tests++; if (retry_a !== 2'd0 || busy_a !== 1'b0 || req_ready_a !== 1'b1) begin
      fails++; $display("FAIL reset_idle: retry=%0d busy=%b rdy=%b want 0 0 1", retry_a, busy_a, req_ready_a);
    end
    @(posedge clk); #3;
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done_width: got %b want 0", done_a); end
  endtask
  task automatic test_ratio_change;
    logic [9:0] bad [3] = '{10'd0, 10'd200, 10'd129};
    request_a(10'd10);
    tests++; if (dyn_a !== 10'd10 || pll_rst_a !== 1'b1 || clk_ok_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++; $display("FAIL ratio_accept: div=%0d rst=%b ok=%b busy=%b want 10 1 0 1", dyn_a, pll_rst_a, clk_ok_a, busy_a);
    end
    request_a(10'd7);
    tests++; if (dyn_a !== 10'd10 || err_a !== 1'b0) begin fails++; $display("FAIL busy_ignore: div=%0d err=%b want 10 0", dyn_a, err_a); end
    relock_checks("ratio", 10'd10);
    foreach (bad[i]) begin
      request_a(bad[i]);
      tests++; if (err_a !== 1'b1 || dyn_a !== 10'd10 || clk_ok_a !== 1'b1 || req_ready_a !== 1'b1) begin
        fails++; $display("FAIL range_%0d: err=%b div=%0d ok=%b rdy=%b want 1 10 1 1", bad[i], err_a, dyn_a, clk_ok_a, req_ready_a);
      end
      @(posedge clk); #3;
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL range_%0d_width: err=%b want 0", bad[i], err_a); end
    end
  endtask
  task automatic test_glitch;
    int n, early;
    request_a(10'd128);
    tests++; if (dyn_a !== 10'd128) begin fails++; $display("FAIL div_max_accept: got %0d want 128", dyn_a); end
    for (n = 0; n < 400 && !pll_lock_a; n++) begin
      @(posedge clk); #3;
    end
    early = 0;
    repeat (500) begin
      @(posedge clk); #3;
      if (clk_ok_a || done_a) early++;
    end
    tests++; if (early !== 0 || n >= 400) begin fails++; $display("FAIL glitch_pre: early=%0d wait=%0d want 0 and lock", early, n); end
    @(negedge clk);
    kill_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    kill_a = 1'b0;
    relock_checks("glitch", 10'd128);
  endtask
  task automatic test_lock_drop;
    int k;
    @(negedge clk);
    kill_a = 1'b1;
    for (k = 1; k <= 4; k++) begin
      @(posedge clk); #3;
      if (!clk_ok_a) break;
    end
    tests++; if (k > 3) begin fails++; $display("FAIL drop_clk_ok: got %0d cycles want <=3", k); end
    @(posedge clk); #3;
    tests++; if (pll_rst_a !== 1'b1 || dyn_a !== 10'd128 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      fails++; $display("FAIL drop_restart: rst=%b div=%0d busy=%b done=%b want 1 128 1 0", pll_rst_a, dyn_a, busy_a, done_a);
    end
    @(negedge clk);
    kill_a = 1'b0;
    relock_checks("drop", 10'd128);
  endtask
  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    kill_a = 1'b1;
    repeat (3) @(posedge clk);
    request_a(10'd8);
    tests++; if (dyn_a !== 10'd8 || pll_rst_a !== 1'b1 || err_a !== 1'b0) begin
      fails++; $display("FAIL simul_accept: div=%0d rst=%b err=%b want 8 1 0", dyn_a, pll_rst_a, err_a);
    end
    @(negedge clk);
    kill_a = 1'b0;
    for (k = 1; k < 40; k++) begin
      @(posedge clk); #3;
      if (!pll_rst_a) break;
    end
    tests++; if (k !== 16) begin fails++; $display("FAIL simul_single_hold: got %0d cycles want 16", k); end
    relock_checks("simul", 10'd8);
  endtask
  task automatic test_rst_mid;
    int k;
    request_a(10'd20);
    for (k = 0; k < 40 && pll_rst_a; k++) begin
      @(posedge clk); #3;
    end
    repeat (10) @(posedge clk);
    #3;
    tests++; if (pll_rst_a !== 1'b0 || busy_a !== 1'b1 || dyn_a !== 10'd20) begin
      fails++; $display("FAIL mid_wait_lock: rst=%b busy=%b div=%0d want 0 1 20", pll_rst_a, busy_a, dyn_a);
    end
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk); #3;
    tests++; if ({pll_rst_a, clk_ok_a, busy_a, done_a, err_a, fault_a, req_ready_a} !== 7'b1010000 || dyn_a !== 10'd5 || retry_a !== 2'd0) begin
      fails++; $display("FAIL mid_reset: rst=%b ok=%b busy=%b done=%b err=%b fault=%b rdy=%b div=%0d retry=%0d want 1 0 1 0 0 0 0 5 0",
        pll_rst_a, clk_ok_a, busy_a, done_a, err_a, fault_a, req_ready_a, dyn_a, retry_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    relock_checks("mid", 10'd5);
  endtask
  task automatic test_timeout;
    int k, falls;
    logic prev;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    falls = 0;
    prev = 1'b1;
    for (k = 1; k < 1000; k++) begin
      @(posedge clk); #3;
      if (prev && !pll_rst_b) falls++;
      prev = pll_rst_b;
      if (done_b) break;
    end
    tests++; if (k !== 468) begin fails++; $display("FAIL timeout_done_at: got %0d want 468", k); end
    tests++; if (falls !== 4) begin fails++; $display("FAIL timeout_attempts: got %0d want 4", falls); end
    tests++; if (fault_b !== 1'b1 || retry_b !== 2'd3 || pll_rst_b !== 1'b1 || clk_ok_b !== 1'b0) begin
      fails++; $display("FAIL timeout_fault: fault=%b retry=%0d rst=%b ok=%b want 1 3 1 0", fault_b, retry_b, pll_rst_b, clk_ok_b);
    end
    repeat (20) @(posedge clk);
    #3;
    tests++; if (fault_b !== 1'b1 || pll_rst_b !== 1'b1 || busy_b !== 1'b0 || req_ready_b !== 1'b1 || done_b !== 1'b0) begin
      fails++; $display("FAIL fault_hold: fault=%b rst=%b busy=%b rdy=%b done=%b want 1 1 0 1 0", fault_b, pll_rst_b, busy_b, req_ready_b, done_b);
    end
    @(negedge clk);
    req_valid_b = 1'b1;
    req_odiv_b = 10'd5;
    @(posedge clk); #3;
    req_valid_b = 1'b0;
    tests++; if (fault_b !== 1'b0 || busy_b !== 1'b1 || pll_rst_b !== 1'b1 || retry_b !== 2'd0 || dyn_b !== 10'd5) begin
      fails++; $display("FAIL fault_clear: fault=%b busy=%b rst=%b retry=%0d div=%0d want 0 1 1 0 5", fault_b, busy_b, pll_rst_b, retry_b, dyn_b);
    end
  endtask
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    req_valid_a = 1'b0;
    req_odiv_a = '0;
    req_valid_b = 1'b0;
    req_odiv_b = '0;
    pll_lock_b = 1'b0;
    test_reset;
    test_ratio_change;
    test_glitch;
    test_lock_drop;
    test_back_to_back;
    test_rst_mid;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
